systolic_feed_sequencer: RTL

//   Sequences the READ phase of the systolic TPU. Pops K_LEN beats from the data FIFO and the weight FIFO.

---
 rtl/systolic_feed_sequencer_if.sv | 64 ++++++
 rtl/systolic_feed_sequencer.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_feed_sequencer_if.sv
// ----------------------------------------------------------------------------
// systolic_feed_sequencer_if
//   Bundle between the READ-phase feed sequencer, the two input FIFOs, the
//   phase FSM and the west/north edges of the PE array.
//
//   Signals (direction seen from the sequencer, modport slave):
//     read_start   in   level request from phase FSM
//     data_rdata   in   data FIFO head, element i = [i*DATAWIDTH +: DATAWIDTH]
//     data_rempty  in   data FIFO empty
//     wgt_rdata    in   weight FIFO head, same packing as data_rdata
//     wgt_rempty   in   weight FIFO empty
//     data_ren     out  data FIFO pop
//     wgt_ren      out  weight FIFO pop
//     row_data     out  skewed operands into array rows
//     row_valid    out  per-row valid
//     col_wgt      out  skewed weights into array columns
//     col_valid    out  per-column valid
//     read_done    out  read phase complete (level)
//     busy         out  high in FETCH, DRAIN and DONE
//     stall_cnt    out  FETCH cycles lost to an empty FIFO
//                       (present only when FEED_STALL_CNT_EN is defined)
//
//   modport slave  : the sequencer
//   modport master : the environment (FIFOs + phase FSM + array)
// ----------------------------------------------------------------------------
interface systolic_feed_sequencer_if #(
    parameter int DATAWIDTH  = 16,
    parameter int ARRAY_SIZE = 2
);
    logic                            read_start;
    logic [ARRAY_SIZE*DATAWIDTH-1:0] data_rdata;
    logic                            data_rempty;
    logic [ARRAY_SIZE*DATAWIDTH-1:0] wgt_rdata;
    logic                            wgt_rempty;
    logic                            data_ren;
    logic                            wgt_ren;
    logic [ARRAY_SIZE*DATAWIDTH-1:0] row_data;
    logic [ARRAY_SIZE-1:0]           row_valid;
    logic [ARRAY_SIZE*DATAWIDTH-1:0] col_wgt;
    logic [ARRAY_SIZE-1:0]           col_valid;
    logic                            read_done;
    logic                            busy;
`ifdef FEED_STALL_CNT_EN
    logic [15:0]                     stall_cnt;
`endif

    modport slave (
        input  read_start, data_rdata, data_rempty, wgt_rdata, wgt_rempty,
        output data_ren, wgt_ren, row_data, row_valid, col_wgt, col_valid,
               read_done, busy
`ifdef FEED_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    modport master (
        output read_start, data_rdata, data_rempty, wgt_rdata, wgt_rempty,
        input  data_ren, wgt_ren, row_data, row_valid, col_wgt, col_valid,
               read_done, busy
`ifdef FEED_STALL_CNT_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/systolic_feed_sequencer.sv
// ----------------------------------------------------------------------------
// systolic_feed_sequencer
//   READ-phase sequencer of the systolic array. Pops K_LEN beats from the
//   data and weight FIFOs (always together), and feeds element i of each beat
//   to row i / column i delayed by i cycles so that operands meet in the PEs.
//   After the last beat has left the skew pipeline it raises read_done until
//   the phase FSM drops read_start.
//
//   Ports:
//     clk   in  rising-edge clock
//     rst   in  asynchronous reset, active-high
//     feed  systolic_feed_sequencer_if.slave (FIFO heads/pops, array edge
//           operands and valids, read_start/read_done/busy handshake)
//
//   Optional feature: define FEED_STALL_CNT_EN to add feed.stall_cnt, a
//   saturating count of FETCH cycles in which a pop was wanted but a FIFO
//   was empty.
// ----------------------------------------------------------------------------
module systolic_feed_sequencer #(
    parameter int DATAWIDTH  = 16,
    parameter int ARRAY_SIZE = 2,
    parameter int K_LEN      = 4
) (
    input logic clk,
    input logic rst,
    systolic_feed_sequencer_if.slave feed
);
    localparam int BW  = $clog2(K_LEN + 1);
    localparam int DCW = $clog2(ARRAY_SIZE);
    localparam logic [BW-1:0]  K_LAST = BW'(K_LEN);
    localparam logic [DCW-1:0] D_LAST = DCW'(ARRAY_SIZE - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [BW-1:0]  r_beat_cnt;
    logic [DCW-1:0] r_drain_cnt;

    logic w_pop;
    logic w_shift;
    logic w_abort;
    logic w_enter_fetch;
    logic w_enter_drain;

    // Lane outputs collected per element, packed onto the bus below.
    logic [DATAWIDTH-1:0] w_lane_dat [ARRAY_SIZE];
    logic [DATAWIDTH-1:0] w_lane_wgt [ARRAY_SIZE];
    logic                 w_lane_vld [ARRAY_SIZE];

    // Both FIFOs are popped in the same cycle or not at all, so every lane
    // sees the same beat (or the same bubble) on the same cycle.
    assign w_pop = (r_state == S_FETCH) & ~feed.data_rempty & ~feed.wgt_rempty
                   & (r_beat_cnt < K_LAST);
    assign w_shift       = (r_state == S_FETCH) | (r_state == S_DRAIN);
    assign w_abort       = w_shift & ~feed.read_start;
    assign w_enter_fetch = (r_state == S_IDLE)  & (w_next_state == S_FETCH);
    assign w_enter_drain = (r_state == S_FETCH) & (w_next_state == S_DRAIN);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (feed.read_start) w_next_state = S_FETCH;
            end
            S_FETCH: begin
                // Leave one cycle after the last pop so the pipeline keeps
                // shifting while the count is already saturated.
                if (!feed.read_start)          w_next_state = S_IDLE;
                else if (r_beat_cnt == K_LAST) w_next_state = S_DRAIN;
            end
            S_DRAIN: begin
                if (!feed.read_start)           w_next_state = S_IDLE;
                else if (r_drain_cnt == D_LAST) w_next_state = S_DONE;
            end
            S_DONE: begin
                // Holding read_start high here must not start a new tile.
                if (!feed.read_start) w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------- counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_beat_cnt <= '0;
        end else if (w_abort || w_enter_fetch) begin
            r_beat_cnt <= '0;
        end else if (w_pop) begin
            r_beat_cnt <= r_beat_cnt + BW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_drain_cnt <= '0;
        end else if (w_abort || w_enter_drain) begin
            r_drain_cnt <= '0;
        end else if ((r_state == S_DRAIN) && (r_drain_cnt != D_LAST)) begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
        end
    end

    // ------------------------------------------------------- skew pipeline
    // Lane gi is a shift chain of gi+1 stages; stage 0 captures the FIFO
    // head (or a zero bubble when nothing is popped), the last stage drives
    // the array edge.
    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            logic [DATAWIDTH-1:0] r_dat [gi+1];
            logic [DATAWIDTH-1:0] r_wgt [gi+1];
            logic                 r_vld [gi+1];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int s = 0; s <= gi; s++) begin
                        r_dat[s] <= '0;
                        r_wgt[s] <= '0;
                        r_vld[s] <= 1'b0;
                    end
                end else if (w_abort) begin
                    // Words already popped in an aborted phase are dropped.
                    for (int s = 0; s <= gi; s++) begin
                        r_dat[s] <= '0;
                        r_wgt[s] <= '0;
                        r_vld[s] <= 1'b0;
                    end
                end else if (w_shift) begin
                    r_dat[0] <= w_pop ? feed.data_rdata[gi*DATAWIDTH +: DATAWIDTH] : '0;
                    r_wgt[0] <= w_pop ? feed.wgt_rdata[gi*DATAWIDTH +: DATAWIDTH]  : '0;
                    r_vld[0] <= w_pop;
                    for (int s = 1; s <= gi; s++) begin
                        r_dat[s] <= r_dat[s-1];
                        r_wgt[s] <= r_wgt[s-1];
                        r_vld[s] <= r_vld[s-1];
                    end
                end
            end

            assign w_lane_dat[gi] = r_dat[gi];
            assign w_lane_wgt[gi] = r_wgt[gi];
            assign w_lane_vld[gi] = r_vld[gi];
        end
    endgenerate

    always_comb begin
        feed.row_data  = '0;
        feed.col_wgt   = '0;
        feed.row_valid = '0;
        feed.col_valid = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            feed.row_data[i*DATAWIDTH +: DATAWIDTH] = w_lane_dat[i];
            feed.col_wgt[i*DATAWIDTH +: DATAWIDTH]  = w_lane_wgt[i];
            feed.row_valid[i] = w_lane_vld[i];
            feed.col_valid[i] = w_lane_vld[i];
        end
    end

    assign feed.data_ren  = w_pop;
    assign feed.wgt_ren   = w_pop;
    assign feed.read_done = (r_state == S_DONE);
    assign feed.busy      = (r_state != S_IDLE);

`ifdef FEED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_abort || w_enter_fetch) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_FETCH) && (r_beat_cnt < K_LAST)
                     && (feed.data_rempty || feed.wgt_rempty)
                     && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign feed.stall_cnt = r_stall_cnt;
`endif

endmodule
